// File: rtl/fifo_rptr_empty.sv
// Read-side pointer and empty-flag logic for an asynchronous FIFO (optional level/almost-empty via FIFO_RD_LEVEL_EN).
// Latency: R_ptr/R_empty/R_level/R_aempty update on the same R_CLK edge that performs a pop; R_addr follows rbin combinationally.
// Backpressure: pops are gated by R_empty; a read attempted while empty is dropped and recorded in sticky R_underflow.
module fifo_rptr_empty #(
    parameter int ADDR_FIFO     = 4,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                 R_CLK,
    input  logic                 R_rst_n,
    input  logic                 R_inc,
    input  logic [ADDR_FIFO:0]   Rq2_wptr,
    input  logic                 R_underflow_clr,
    output logic [ADDR_FIFO-1:0] R_addr,
    output logic [ADDR_FIFO:0]   R_ptr,
    output logic                 R_empty,
    output logic                 R_underflow
`ifdef FIFO_RD_LEVEL_EN
    ,
    output logic [ADDR_FIFO:0]   R_level,
    output logic                 R_aempty
`endif
);

    localparam int PTR_W = ADDR_FIFO + 1;

    logic [PTR_W-1:0] rbin;
    logic [PTR_W-1:0] rbin_next;
    logic [PTR_W-1:0] rgray_next;
    logic             pop;

    // A pop is only honoured while the registered empty flag is clear.
    always_comb begin
        pop        = R_inc & ~R_empty;
        rbin_next  = rbin + PTR_W'(pop);
        rgray_next = (rbin_next >> 1) ^ rbin_next;
    end

    assign R_addr = rbin[ADDR_FIFO-1:0];

    // Pointer and empty registers; empty compares the post-pop Gray pointer so there is no bubble.
    always_ff @(posedge R_CLK or negedge R_rst_n) begin
        if (!R_rst_n) begin
            rbin    <= '0;
            R_ptr   <= '0;
            R_empty <= 1'b1;
        end else begin
            rbin    <= rbin_next;
            R_ptr   <= rgray_next;
            R_empty <= (rgray_next == Rq2_wptr);
        end
    end

    // Sticky underflow: a new underflow wins over a simultaneous clear.
    always_ff @(posedge R_CLK or negedge R_rst_n) begin
        if (!R_rst_n) begin
            R_underflow <= 1'b0;
        end else if (R_inc && R_empty) begin
            R_underflow <= 1'b1;
        end else if (R_underflow_clr) begin
            R_underflow <= 1'b0;
        end
    end

`ifdef FIFO_RD_LEVEL_EN
    localparam logic [PTR_W-1:0] AEMPTY_LVL = PTR_W'(AEMPTY_THRESH);

    logic [PTR_W-1:0] wbin_s;
    logic [PTR_W-1:0] level_next;

    // Gray-to-binary of the synchronized write pointer, then modular distance to the post-pop read pointer.
    always_comb begin
        wbin_s = '0;
        for (int i = 0; i < PTR_W; i++) begin
            wbin_s[i] = ^(Rq2_wptr >> i);
        end
        level_next = wbin_s - rbin_next;
    end

    // Registered fill level and almost-empty flag, aligned with R_empty.
    always_ff @(posedge R_CLK or negedge R_rst_n) begin
        if (!R_rst_n) begin
            R_level  <= '0;
            R_aempty <= 1'b1;
        end else begin
            R_level  <= level_next;
            R_aempty <= (level_next <= AEMPTY_LVL);
        end
    end
`endif

endmodule

// File: tb/tb_fifo_rptr_empty.sv
// Directed bench for fifo_rptr_empty (ADDR_FIFO=4, AEMPTY_THRESH=2).
// Inputs change #1 after each R_CLK rising edge; outputs are checked there too.
// Level checks are compiled in only when FIFO_RD_LEVEL_EN is defined.
module tb_fifo_rptr_empty;

    logic       R_CLK = 1'b0;
    logic       R_rst_n;
    logic       R_inc;
    logic [4:0] Rq2_wptr;
    logic       R_underflow_clr;
    logic [3:0] R_addr;
    logic [4:0] R_ptr;
    logic       R_empty;
    logic       R_underflow;
`ifdef FIFO_RD_LEVEL_EN
    logic [4:0] R_level;
    logic       R_aempty;
`endif

    int vectors = 0;
    int fails   = 0;

    fifo_rptr_empty #(.ADDR_FIFO(4), .AEMPTY_THRESH(2)) dut (
        .R_CLK           (R_CLK),
        .R_rst_n         (R_rst_n),
        .R_inc           (R_inc),
        .Rq2_wptr        (Rq2_wptr),
        .R_underflow_clr (R_underflow_clr),
        .R_addr          (R_addr),
        .R_ptr           (R_ptr),
        .R_empty         (R_empty),
        .R_underflow     (R_underflow)
`ifdef FIFO_RD_LEVEL_EN
        ,
        .R_level         (R_level),
        .R_aempty        (R_aempty)
`endif
    );

    always #5 R_CLK = ~R_CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge R_CLK);
        #1;
    endtask

    function automatic logic [4:0] gray(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [4:0] wb;
    logic [4:0] prev_ptr;

    initial begin
        // ---- reset state ----
        R_rst_n = 1'b0; R_inc = 1'b0; Rq2_wptr = 5'd0; R_underflow_clr = 1'b0;
        step(); step();
        chk("rst_empty", 32'(R_empty), 32'd1);
        chk("rst_addr", 32'(R_addr), 32'd0);
        chk("rst_ptr", 32'(R_ptr), 32'd0);
        chk("rst_uflow", 32'(R_underflow), 32'd0);
`ifdef FIFO_RD_LEVEL_EN
        chk("rst_level", 32'(R_level), 32'd0);
        chk("rst_aempty", 32'(R_aempty), 32'd1);
`endif
        R_rst_n = 1'b1;

        // ---- reads while empty: nothing moves, underflow sets on first edge ----
        R_inc = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("ue_empty", 32'(R_empty), 32'd1);
            chk("ue_addr", 32'(R_addr), 32'd0);
            chk("ue_ptr", 32'(R_ptr), 32'd0);
            chk("ue_uflow", 32'(R_underflow), 32'd1);
        end

        // ---- set beats clear on the same edge, then clear alone ----
        R_underflow_clr = 1'b1;
        step();
        chk("clr_vs_set", 32'(R_underflow), 32'd1);
        R_inc = 1'b0;
        step();
        chk("clr_only", 32'(R_underflow), 32'd0);
        R_underflow_clr = 1'b0;

        // ---- two words written (Gray 0->1->3), two pops ----
        Rq2_wptr = 5'b00001;
        step();
        chk("w1_empty", 32'(R_empty), 32'd0);
        Rq2_wptr = 5'b00011;
        step();
        chk("w2_empty", 32'(R_empty), 32'd0);
        chk("pop0_addr", 32'(R_addr), 32'd0);
        R_inc = 1'b1;
        step();
        chk("pop1_addr", 32'(R_addr), 32'd1);
        chk("pop1_empty", 32'(R_empty), 32'd0);
        chk("pop1_ptr", 32'(R_ptr), 32'b00001);
        step();
        chk("pop2_empty", 32'(R_empty), 32'd1);
        chk("pop2_ptr", 32'(R_ptr), 32'b00011);
        chk("pop2_addr", 32'(R_addr), 32'd2);
        step();
        chk("hold_addr", 32'(R_addr), 32'd2);
        chk("hold_ptr", 32'(R_ptr), 32'b00011);
        R_inc = 1'b0; R_underflow_clr = 1'b1;
        step();
        R_underflow_clr = 1'b0;

        // ---- full FIFO drained by continuous reads ----
        R_rst_n = 1'b0;
        #1;
        chk("rst2_addr", 32'(R_addr), 32'd0);
        chk("rst2_ptr", 32'(R_ptr), 32'd0);
        step();
        R_rst_n = 1'b1;
        Rq2_wptr = 5'b11000;   // Gray(16)
        R_inc = 1'b1;
        step();                // empty was 1: no pop on this edge
        for (int i = 0; i < 16; i++) begin
            chk("full_addr", 32'(R_addr), 32'(i));
            chk("full_empty", 32'(R_empty), 32'd0);
`ifdef FIFO_RD_LEVEL_EN
            chk("full_level", 32'(R_level), 32'(16 - i));
            chk("full_aempty", 32'(R_aempty), ((16 - i) <= 2) ? 32'd1 : 32'd0);
`endif
            step();
        end
        chk("drain_empty", 32'(R_empty), 32'd1);
        chk("drain_addr", 32'(R_addr), 32'd0);
        chk("drain_ptr", 32'(R_ptr), 32'b11000);
`ifdef FIFO_RD_LEVEL_EN
        chk("drain_level", 32'(R_level), 32'd0);
        chk("drain_aempty", 32'(R_aempty), 32'd1);
`endif
        step();
        chk("drain_hold_addr", 32'(R_addr), 32'd0);
        chk("drain_uflow", 32'(R_underflow), 32'd1);

        // ---- 40 words streamed through the pointer wrap ----
        R_inc = 1'b1; R_underflow_clr = 1'b0;
        wb = 5'd16;
        prev_ptr = R_ptr;
        for (int k = 1; k <= 40; k++) begin
            wb = wb + 5'd1;
            Rq2_wptr = gray(wb);
            step();
            chk("wrap_empty", 32'(R_empty), 32'd0);
            chk("wrap_addr", 32'(R_addr), 32'((16 + k - 1) % 16));
            if (k > 1) chk("wrap_1bit", 32'($countones(R_ptr ^ prev_ptr)), 32'd1);
            prev_ptr = R_ptr;
        end
        step();                // catches up with the writer: rbin 55 -> 56 mod 32 = 24
        chk("wrap_end_empty", 32'(R_empty), 32'd1);
        chk("wrap_end_ptr", 32'(R_ptr), 32'(gray(5'd24)));

        // ---- reset mid-burst after 7 pops ----
        R_inc = 1'b0; R_underflow_clr = 1'b1;
        R_rst_n = 1'b0;
        step();
        R_rst_n = 1'b1; R_underflow_clr = 1'b0;
        Rq2_wptr = 5'b11000;
        R_inc = 1'b1;
        step();
        for (int i = 0; i < 7; i++) step();
        chk("mid_addr", 32'(R_addr), 32'd7);
        R_rst_n = 1'b0;
        #1;
        chk("mid_rst_addr", 32'(R_addr), 32'd0);
        chk("mid_rst_ptr", 32'(R_ptr), 32'd0);
        chk("mid_rst_empty", 32'(R_empty), 32'd1);
        chk("mid_rst_uflow", 32'(R_underflow), 32'd0);
`ifdef FIFO_RD_LEVEL_EN
        chk("mid_rst_level", 32'(R_level), 32'd0);
        chk("mid_rst_aempty", 32'(R_aempty), 32'd1);
`endif
        step();
        R_rst_n = 1'b1;
        step();                // no pop while registered empty; empty clears
        chk("post_rst_addr", 32'(R_addr), 32'd0);
        chk("post_rst_empty", 32'(R_empty), 32'd0);
        step();
        chk("post_rst_pop", 32'(R_addr), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
